// File: rtl/contador_pkg.sv
// Shared counter definitions: mode encodings and helpers reused by the counter family.
package contador_pkg;

    localparam logic [1:0] MODE_WRAP     = 2'b00;
    localparam logic [1:0] MODE_SAT      = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;
    localparam logic [1:0] MODE_WRAP_ALT = 2'b11;

    // Encoding 11 is reserved and behaves like wrap.
    function automatic logic is_wrap(input logic [1:0] m);
        return (m == MODE_WRAP) || (m == MODE_WRAP_ALT);
    endfunction

endpackage

// File: rtl/contador_mod_param.sv
// Up/down counter over 0..lim with wrap, saturate and one-shot terminal behaviour,
// run-time writable limit, and clamped parallel load.
module contador_mod_param
    import contador_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LIM_INIT  = 2,
    parameter int RESET_VAL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             lim_we,
    input  logic [WIDTH-1:0] lim_in,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] lim,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] LIM_RST = WIDTH'(LIM_INIT);
    localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_nx, lim_nx, term;
    logic             done_nx, frozen;

    assign term   = dir ? lim : '0;
    assign frozen = done && (mode == MODE_ONESHOT);
    assign tc     = en && !load && (count == term);

    always_comb begin
        lim_nx   = lim_we ? lim_in : lim;
        count_nx = count;
        done_nx  = done;
        if (load) begin
            // Clamp against the limit that will be live next cycle.
            count_nx = (load_val > lim_nx) ? lim_nx : load_val;
            done_nx  = 1'b0;
        end else begin
            if (mode != MODE_ONESHOT)
                done_nx = 1'b0;
            if (en && !frozen) begin
                // A shrunken limit can leave count above it; pull it back in range.
                if (count > lim)
                    count_nx = (dir && is_wrap(mode)) ? '0 : lim;
                else if (count == term) begin
                    if (is_wrap(mode))
                        count_nx = dir ? '0 : lim;
                    else if (mode == MODE_ONESHOT)
                        done_nx = 1'b1;
                end else
                    count_nx = dir ? count + ONE : count - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= CNT_RST;
            lim   <= LIM_RST;
            done  <= 1'b0;
        end else begin
            count <= count_nx;
            lim   <= lim_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_contador_mod_param.sv
// Directed bench for contador_mod_param: vector table plus async-reset sequence.
module tb_contador_mod_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, dir, load, lim_we;
    logic [1:0] mode;
    logic [3:0] load_val, lim_in;
    logic [3:0] count, lim;
    logic       tc, done;

    int checks = 0;
    int errors = 0;

    contador_mod_param #(.WIDTH(4), .LIM_INIT(2), .RESET_VAL(2)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .lim_we(lim_we), .lim_in(lim_in),
        .count(count), .lim(lim), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, dir;
        logic [1:0] mode;
        logic       load;
        logic [3:0] load_val;
        logic       lim_we;
        logic [3:0] lim_in;
        logic       e_tc;
        logic [3:0] e_count, e_lim;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic d, logic [1:0] m, logic ld, logic [3:0] lv,
                                logic lw, logic [3:0] li, logic xtc, logic [3:0] xc,
                                logic [3:0] xl, logic xd);
        vec_t v;
        v.en = e; v.dir = d; v.mode = m; v.load = ld; v.load_val = lv;
        v.lim_we = lw; v.lim_in = li; v.e_tc = xtc; v.e_count = xc; v.e_lim = xl; v.e_done = xd;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic d, input logic [1:0] m, input logic ld,
                         input logic [3:0] lv, input logic lw, input logic [3:0] li);
        en = e; dir = d; mode = m; load = ld; load_val = lv; lim_we = lw; lim_in = li;
    endtask

    initial begin
        drive(0, 0, 2'b00, 0, 0, 0, 0);
        reset = 1'b0;

        // wrap down from reset value 2 with lim 2
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 0,1,2,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 0,0,2,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 1,2,2,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 0,1,2,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 0,0,2,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 1,2,2,0));
        // limit to 5, saturate up
        vecs.push_back(mk(0,0,2'b00,0,0,1,5, 0,2,5,0));
        vecs.push_back(mk(1,1,2'b01,0,0,0,0, 0,3,5,0));
        vecs.push_back(mk(1,1,2'b01,0,0,0,0, 0,4,5,0));
        vecs.push_back(mk(1,1,2'b01,0,0,0,0, 0,5,5,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,1,2'b01,0,0,0,0, 1,5,5,0));
        // one-shot down from 3
        vecs.push_back(mk(1,0,2'b10,1,3,0,0, 0,3,5,0));
        vecs.push_back(mk(1,0,2'b10,0,0,0,0, 0,2,5,0));
        vecs.push_back(mk(1,0,2'b10,0,0,0,0, 0,1,5,0));
        vecs.push_back(mk(1,0,2'b10,0,0,0,0, 0,0,5,0));
        vecs.push_back(mk(1,0,2'b10,0,0,0,0, 1,0,5,1));
        vecs.push_back(mk(1,0,2'b10,0,0,0,0, 1,0,5,1));
        vecs.push_back(mk(1,1,2'b10,0,0,0,0, 0,0,5,1));  // en ignored while done, even dir=1
        vecs.push_back(mk(1,0,2'b10,1,2,0,0, 0,2,5,0));
        vecs.push_back(mk(1,0,2'b10,0,0,0,0, 0,1,5,0));
        vecs.push_back(mk(1,0,2'b10,0,0,0,0, 0,0,5,0));
        vecs.push_back(mk(1,0,2'b10,0,0,0,0, 1,0,5,1));
        vecs.push_back(mk(0,0,2'b00,0,0,0,0, 0,0,5,0));  // leaving one-shot clears done
        // limit decrease below count
        vecs.push_back(mk(0,0,2'b00,1,5,0,0, 0,5,5,0));
        vecs.push_back(mk(0,0,2'b00,0,0,1,3, 0,5,3,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 0,3,3,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 0,2,3,0));
        vecs.push_back(mk(0,0,2'b00,1,5,1,5, 0,5,5,0));
        vecs.push_back(mk(0,0,2'b00,0,0,1,3, 0,5,3,0));
        vecs.push_back(mk(1,1,2'b00,0,0,0,0, 0,0,3,0));
        vecs.push_back(mk(0,0,2'b00,1,5,1,5, 0,5,5,0));
        vecs.push_back(mk(0,0,2'b00,0,0,1,3, 0,5,3,0));
        vecs.push_back(mk(1,1,2'b01,0,0,0,0, 0,3,3,0));
        vecs.push_back(mk(1,1,2'b11,0,0,0,0, 1,0,3,0));  // mode 11 wraps
        // load clamping
        vecs.push_back(mk(0,0,2'b00,0,0,1,4, 0,0,4,0));
        vecs.push_back(mk(1,0,2'b00,1,9,0,0, 0,4,4,0));
        vecs.push_back(mk(0,0,2'b00,1,9,1,7, 0,7,7,0));
        // lim = 0
        vecs.push_back(mk(0,0,2'b00,0,0,1,0, 0,7,0,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,2'b00,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,2'b01,0,0,0,0, 1,0,0,0));

        @(negedge clk);
        @(negedge clk);
        chk("reset count", count, 2);
        chk("reset lim", lim, 2);
        chk("reset done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load,
                  vecs[i].load_val, vecs[i].lim_we, vecs[i].lim_in);
            #1;
            chk($sformatf("v%0d tc", i), tc, vecs[i].e_tc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), count, vecs[i].e_count);
            chk($sformatf("v%0d lim", i), lim, vecs[i].e_lim);
            chk($sformatf("v%0d done", i), done, vecs[i].e_done);
            @(negedge clk);
        end

        // async reset mid-period, with done set and a load pending
        drive(0, 0, 2'b10, 1, 1, 1, 5);
        @(negedge clk);
        drive(1, 0, 2'b10, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset done", done, 1);
        drive(1, 1, 2'b00, 1, 4, 1, 9);
        #2;
        reset = 1'b0;
        #1;
        chk("async count", count, 2);
        chk("async lim", lim, 2);
        chk("async done", done, 0);
        load = 1'b0;
        #1;
        chk("reset tc", tc, 1);
        @(negedge clk);
        chk("held count", count, 2);
        drive(1, 0, 2'b00, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("first edge count", count, 1);
        chk("first edge lim", lim, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
